exec_unit_pipe: RTL and testbench

Parametrised, registered successor to the single-cycle integer/branch execution unit. It accepts one issued instruction per valid/ready handshake and executes ALU, branch and jump operations in one cycle. It adds a pipelined multiplier and an iterative signed divider with a real busy/back-pressure path. It sits between issue/register-read and the writeback/branch-redirect logic of the core.

---
 rtl/exec_pkg.sv | 42 ++++
 rtl/exec_unit_pipe_div.sv | 100 ++++++++++
 rtl/exec_unit_pipe.sv | 227 ++++++++++++++++++++++
 tb/tb_exec_unit_pipe.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// Shared op encoding and decode helpers for the
// registered integer/branch execution unit.
package exec_pkg;

  typedef enum logic [4:0] {
    OP_NOP  = 5'd0,
    OP_ADD  = 5'd1,
    OP_SUB  = 5'd2,
    OP_AND  = 5'd3,
    OP_OR   = 5'd4,
    OP_XOR  = 5'd5,
    OP_SLT  = 5'd6,
    OP_SLL  = 5'd7,
    OP_SRL  = 5'd8,
    OP_SRA  = 5'd9,
    OP_LUI  = 5'd10,
    OP_MUL  = 5'd11,
    OP_DIV  = 5'd12,
    OP_REM  = 5'd13,
    OP_BEQ  = 5'd14,
    OP_BNE  = 5'd15,
    OP_BLT  = 5'd16,
    OP_BLE  = 5'd17,
    OP_JR   = 5'd18,
    OP_JALR = 5'd19
  } op_e;

  typedef enum logic [1:0] {
    DV_IDLE = 2'd0,
    DV_ITER = 2'd1,
    DV_FIX  = 2'd2
  } div_state_e;

  function automatic logic is_branch(input op_e op);
    return op inside {[OP_BEQ:OP_JALR]};
  endfunction

  function automatic logic is_multicycle(input op_e op);
    return op inside {OP_MUL, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/exec_unit_pipe_div.sv
// Signed restoring divider, one quotient bit per
// cycle on magnitudes, sign applied in the FIX state.
module exec_div_iter
  import exec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            cancel,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] quot,
  output logic [XLEN-1:0] rem
);

  localparam int CW = $clog2(XLEN);

  div_state_e      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
  logic            dz_q, dz_d;
  logic [XLEN:0]   rem_sh, diff;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    rem_sh  = {rem_q, quo_q[XLEN-1]};
    diff    = rem_sh - {1'b0, dvs_q};
    unique case (state_q)
      DV_IDLE: begin
        if (start) begin
          state_d = DV_ITER;
          cnt_d   = '0;
          rem_d   = '0;
          quo_d   = a[XLEN-1] ? -a : a;
          dvs_d   = b[XLEN-1] ? -b : b;
          qneg_d  = a[XLEN-1] ^ b[XLEN-1];
          rneg_d  = a[XLEN-1];
          dz_d    = (b == '0);
        end
      end
      DV_ITER: begin
        cnt_d = cnt_q + CW'(1);
        if (!diff[XLEN]) begin
          rem_d = diff[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], 1'b1};
        end else begin
          rem_d = rem_sh[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], 1'b0};
        end
        if (cnt_q == CW'(XLEN - 1)) state_d = DV_FIX;
      end
      DV_FIX:  state_d = DV_IDLE;
      default: state_d = DV_IDLE;
    endcase
    if (cancel) state_d = DV_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DV_IDLE;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
    end
  end

  // Divide by zero keeps the magnitude remainder, which
  // sign-fixes back to the dividend; only quot is forced.
  assign done = (state_q == DV_FIX);
  assign quot = dz_q ? '1 : (qneg_q ? -quo_q : quo_q);
  assign rem  = rneg_q ? -rem_q : rem_q;

endmodule

// File: rtl/exec_unit_pipe.sv
// Registered integer/branch execution unit with a
// pipelined multiplier and iterative signed divider.
module exec_unit_pipe
  import exec_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int PC_W       = 14,
  parameter int TAG_W      = 6,
  parameter int LINK_TAG   = 31,
  parameter int MUL_STAGES = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_op,
  input  logic [PC_W-1:0]  in_pc,
  input  logic [PC_W-1:0]  in_pred_target,
  input  logic             in_pred_taken,
  input  logic [XLEN-1:0]  in_rs_val,
  input  logic [XLEN-1:0]  in_rt_val,
  input  logic [15:0]      in_imm,
  input  logic             in_use_imm,
  input  logic [TAG_W-1:0] in_dd,
  input  logic             flush,
  output logic             wb_valid,
  output logic [TAG_W-1:0] wb_tag,
  output logic [XLEN-1:0]  wb_val,
  output logic             br_valid,
  output logic             br_taken,
  output logic             br_mispredict,
  output logic [PC_W-1:0]  br_target,
  output logic [PC_W-1:0]  br_pc,
  output logic             busy
);

  localparam int SH_W = $clog2(XLEN);
  localparam int MP   = (MUL_STAGES > 1) ? MUL_STAGES - 1 : 1;

  op_e             op;
  logic            acc, acc_mul, acc_div, acc_mc;
  logic [XLEN-1:0] imm_x, op2, prod, alu_res;
  logic [SH_W-1:0] shamt;
  logic            lt, eq, cond, is_jmp, alu_wb;
  logic [PC_W-1:0] pc_inc, imm_pc, tgt;

  logic            mul_fire;
  logic [XLEN-1:0] mul_res;
  logic [TAG_W-1:0] mul_tag;

  logic            div_done;
  logic [XLEN-1:0] div_quot, div_rem;

  logic             wb_valid_q, wb_valid_d;
  logic [TAG_W-1:0] wb_tag_q, wb_tag_d;
  logic [XLEN-1:0]  wb_val_q, wb_val_d;
  logic             br_valid_q, br_valid_d;
  logic             br_taken_q, br_taken_d;
  logic             br_mis_q, br_mis_d;
  logic [PC_W-1:0]  br_tgt_q, br_tgt_d;
  logic [PC_W-1:0]  br_pc_q, br_pc_d;
  logic             busy_q, busy_d;
  logic [TAG_W-1:0] mc_tag_q, mc_tag_d;
  logic             div_rem_q, div_rem_d;
  logic             mv_q [MP];
  logic             mv_d [MP];
  logic [XLEN-1:0]  mp_q [MP];
  logic [XLEN-1:0]  mp_d [MP];

  assign op       = op_e'(in_op);
  assign in_ready = ~busy_q;
  assign acc      = in_valid & in_ready & ~flush;
  assign acc_mc   = acc & is_multicycle(op);
  assign acc_mul  = acc & (op == OP_MUL);
  assign acc_div  = acc & (op inside {OP_DIV, OP_REM});

  assign imm_x  = XLEN'($signed(in_imm));
  assign op2    = in_use_imm ? imm_x : in_rt_val;
  assign shamt  = op2[SH_W-1:0];
  assign prod   = in_rs_val * op2;
  assign lt     = $signed(in_rs_val) < $signed(op2);
  assign eq     = (in_rs_val == op2);
  assign pc_inc = in_pc + PC_W'(1);
  assign imm_pc = PC_W'($signed(in_imm));

  always_comb begin
    alu_res = '0;
    cond    = 1'b0;
    unique case (op)
      OP_ADD:  alu_res = in_rs_val + op2;
      OP_SUB:  alu_res = in_rs_val - op2;
      OP_AND:  alu_res = in_rs_val & op2;
      OP_OR:   alu_res = in_rs_val | op2;
      OP_XOR:  alu_res = in_rs_val ^ op2;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, lt};
      OP_SLL:  alu_res = in_rs_val << shamt;
      OP_SRL:  alu_res = in_rs_val >> shamt;
      OP_SRA:  alu_res = XLEN'($signed(in_rs_val) >>> shamt);
      OP_LUI:  alu_res = XLEN'({in_imm, 16'(in_rs_val)});
      OP_JALR: alu_res = XLEN'(pc_inc);
      OP_BEQ:  cond = eq;
      OP_BNE:  cond = ~eq;
      OP_BLT:  cond = lt;
      OP_BLE:  cond = lt | eq;
      default: ;
    endcase
  end

  assign alu_wb = op inside {[OP_ADD:OP_LUI], OP_JALR};
  assign is_jmp = op inside {OP_JR, OP_JALR};
  assign tgt    = is_jmp ? PC_W'(in_rs_val)
                         : (cond ? imm_pc : pc_inc);

  // A single-stage multiplier completes in its issue cycle.
  assign mul_fire = (MUL_STAGES == 1) ? acc_mul : mv_q[MP-1];
  assign mul_res  = (MUL_STAGES == 1) ? prod : mp_q[MP-1];
  assign mul_tag  = (MUL_STAGES == 1) ? in_dd : mc_tag_q;

  exec_div_iter #(
    .XLEN(XLEN)
  ) u_div (
    .clk    (clk),
    .rst    (rst),
    .start  (acc_div),
    .cancel (flush),
    .a      (in_rs_val),
    .b      (op2),
    .done   (div_done),
    .quot   (div_quot),
    .rem    (div_rem)
  );

  always_comb begin
    wb_valid_d = 1'b0;
    wb_tag_d   = wb_tag_q;
    wb_val_d   = wb_val_q;
    br_valid_d = 1'b0;
    br_taken_d = br_taken_q;
    br_mis_d   = br_mis_q;
    br_tgt_d   = br_tgt_q;
    br_pc_d    = br_pc_q;
    mc_tag_d   = mc_tag_q;
    div_rem_d  = div_rem_q;
    // While busy only the multi-cycle result can write back.
    busy_d     = busy_q & ~wb_valid_q;
    mv_d[0]    = acc_mul;
    mp_d[0]    = prod;
    for (int i = 1; i < MP; i++) begin
      mv_d[i] = mv_q[i-1];
      mp_d[i] = mp_q[i-1];
    end
    if (acc_mc) begin
      busy_d    = 1'b1;
      mc_tag_d  = in_dd;
      div_rem_d = (op == OP_REM);
    end
    if (flush) begin
      busy_d = 1'b0;
      for (int i = 0; i < MP; i++) mv_d[i] = 1'b0;
    end else if (mul_fire) begin
      wb_valid_d = 1'b1;
      wb_tag_d   = mul_tag;
      wb_val_d   = mul_res;
    end else if (div_done) begin
      wb_valid_d = 1'b1;
      wb_tag_d   = mc_tag_q;
      wb_val_d   = div_rem_q ? div_rem : div_quot;
    end else if (acc) begin
      if (alu_wb) begin
        wb_valid_d = 1'b1;
        wb_tag_d   = (op == OP_JALR) ? TAG_W'(LINK_TAG) : in_dd;
        wb_val_d   = alu_res;
      end
      if (is_branch(op)) begin
        br_valid_d = 1'b1;
        br_taken_d = is_jmp | cond;
        br_mis_d   = is_jmp ? (tgt != in_pred_target)
                            : (cond ^ in_pred_taken);
        br_tgt_d   = tgt;
        br_pc_d    = in_pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_q <= 1'b0;
      wb_tag_q   <= '0;
      wb_val_q   <= '0;
      br_valid_q <= 1'b0;
      br_taken_q <= 1'b0;
      br_mis_q   <= 1'b0;
      br_tgt_q   <= '0;
      br_pc_q    <= '0;
      busy_q     <= 1'b0;
      mc_tag_q   <= '0;
      div_rem_q  <= 1'b0;
      mv_q       <= '{default: 1'b0};
      mp_q       <= '{default: '0};
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_tag_q   <= wb_tag_d;
      wb_val_q   <= wb_val_d;
      br_valid_q <= br_valid_d;
      br_taken_q <= br_taken_d;
      br_mis_q   <= br_mis_d;
      br_tgt_q   <= br_tgt_d;
      br_pc_q    <= br_pc_d;
      busy_q     <= busy_d;
      mc_tag_q   <= mc_tag_d;
      div_rem_q  <= div_rem_d;
      mv_q       <= mv_d;
      mp_q       <= mp_d;
    end
  end

  assign wb_valid      = wb_valid_q;
  assign wb_tag        = wb_tag_q;
  assign wb_val        = wb_val_q;
  assign br_valid      = br_valid_q;
  assign br_taken      = br_taken_q;
  assign br_mispredict = br_mis_q;
  assign br_target     = br_tgt_q;
  assign br_pc         = br_pc_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_exec_unit_pipe.sv
// Scoreboard bench: issue pushes expected results,
// a negedge monitor pops and compares.
module tb_exec_unit_pipe;
  import exec_pkg::*;

  logic        clk, rst;
  logic        in_valid, in_ready;
  logic [4:0]  in_op;
  logic [13:0] in_pc, in_pred_target;
  logic        in_pred_taken;
  logic [31:0] in_rs_val, in_rt_val;
  logic [15:0] in_imm;
  logic        in_use_imm;
  logic [5:0]  in_dd;
  logic        flush;
  logic        wb_valid;
  logic [5:0]  wb_tag;
  logic [31:0] wb_val;
  logic        br_valid, br_taken, br_mispredict;
  logic [13:0] br_target, br_pc;
  logic        busy;

  exec_unit_pipe #(
    .XLEN(32), .PC_W(14), .TAG_W(6),
    .LINK_TAG(31), .MUL_STAGES(3)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_pc(in_pc),
    .in_pred_target(in_pred_target),
    .in_pred_taken(in_pred_taken),
    .in_rs_val(in_rs_val), .in_rt_val(in_rt_val),
    .in_imm(in_imm), .in_use_imm(in_use_imm),
    .in_dd(in_dd), .flush(flush),
    .wb_valid(wb_valid), .wb_tag(wb_tag),
    .wb_val(wb_val), .br_valid(br_valid),
    .br_taken(br_taken),
    .br_mispredict(br_mispredict),
    .br_target(br_target), .br_pc(br_pc),
    .busy(busy)
  );

  typedef struct {
    int          due;
    logic [5:0]  tag;
    logic [31:0] val;
  } wb_exp_t;

  typedef struct {
    int          due;
    logic        tk;
    logic        mp;
    logic [13:0] tgt;
    logic [13:0] pc;
  } br_exp_t;

  wb_exp_t wb_q[$];
  br_exp_t br_q[$];
  wb_exp_t we;
  br_exp_t be;
  int cyc = 0;
  int n_tot = 0;
  int n_pass = 0;
  int a0, a1;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h (cyc %0d)",
                  name, got, exp, cyc);
  endtask

  task automatic bad(input string name);
    n_tot++;
    $display("FAIL %s at cyc %0d", name, cyc);
  endtask

  always @(negedge clk) begin
    #1;
    if (!rst) begin
      if (wb_valid) begin
        if (wb_q.size() == 0) bad("wb_unexpected");
        else begin
          we = wb_q.pop_front();
          chk("wb_tag", 32'(wb_tag), 32'(we.tag));
          chk("wb_val", wb_val, we.val);
          chk("wb_cycle", cyc, we.due);
        end
      end else if (wb_q.size() != 0 && cyc > wb_q[0].due) begin
        bad("wb_missing");
        void'(wb_q.pop_front());
      end
      if (br_valid) begin
        if (br_q.size() == 0) bad("br_unexpected");
        else begin
          be = br_q.pop_front();
          chk("br_taken", 32'(br_taken), 32'(be.tk));
          chk("br_mispredict", 32'(br_mispredict), 32'(be.mp));
          chk("br_target", 32'(br_target), 32'(be.tgt));
          chk("br_pc", 32'(br_pc), 32'(be.pc));
          chk("br_cycle", cyc, be.due);
        end
      end else if (br_q.size() != 0 && cyc > br_q[0].due) begin
        bad("br_missing");
        void'(br_q.pop_front());
      end
    end
  end

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic issue(
    input op_e op, input logic [31:0] rs, input logic [31:0] rt,
    input logic [15:0] imm, input bit ui, input logic [5:0] dd,
    input logic [13:0] pc, input logic [13:0] pt, input bit ptk,
    input int lat, input bit ewb, input logic [5:0] etag,
    input logic [31:0] eval, input bit ebr, input bit etk,
    input bit emp, input logic [13:0] etgt, output int acc);
    int w;
    w = 0;
    in_valid = 1'b1; in_op = op;
    in_rs_val = rs; in_rt_val = rt;
    in_imm = imm; in_use_imm = ui; in_dd = dd;
    in_pc = pc; in_pred_target = pt; in_pred_taken = ptk;
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) bad("issue_timeout");
    acc = cyc;
    if (ewb) wb_q.push_back('{acc + lat, etag, eval});
    if (ebr) br_q.push_back('{acc + 1, etk, emp, etgt, pc});
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic alu_op(input op_e op, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [15:0] imm,
                        input bit ui, input logic [5:0] dd,
                        input logic [31:0] ev);
    int a;
    issue(op, rs, rt, imm, ui, dd, 14'h0, 14'h0, 1'b0,
          1, 1'b1, dd, ev, 1'b0, 1'b0, 1'b0, 14'h0, a);
  endtask

  task automatic mc_op(input op_e op, input logic [31:0] rs,
                       input logic [31:0] rt, input logic [5:0] dd,
                       input int lat, input bit ewb,
                       input logic [31:0] ev, output int a);
    issue(op, rs, rt, 16'h0, 1'b0, dd, 14'h0, 14'h0, 1'b0,
          lat, ewb, dd, ev, 1'b0, 1'b0, 1'b0, 14'h0, a);
  endtask

  task automatic br_op(input op_e op, input logic [31:0] rs,
                       input logic [31:0] rt, input logic [15:0] imm,
                       input logic [13:0] pc, input logic [13:0] pt,
                       input bit ptk, input bit etk, input bit emp,
                       input logic [13:0] etgt, input bit ewb,
                       input logic [31:0] ev);
    int a;
    issue(op, rs, rt, imm, 1'b0, 6'd1, pc, pt, ptk,
          1, ewb, 6'd31, ev, 1'b1, etk, emp, etgt, a);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((wb_q.size() != 0 || br_q.size() != 0) && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (wb_q.size() != 0 || br_q.size() != 0) bad("drain_timeout");
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog at cyc %0d", cyc);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
    in_op = 5'd0; in_pc = '0; in_pred_target = '0;
    in_pred_taken = 1'b0; in_rs_val = '0; in_rt_val = '0;
    in_imm = '0; in_use_imm = 1'b0; in_dd = '0;
    repeat (3) @(negedge clk);
    chk("rst_wb_valid", 32'(wb_valid), 0);
    chk("rst_br_valid", 32'(br_valid), 0);
    chk("rst_wb_val", wb_val, 0);
    chk("rst_wb_tag", 32'(wb_tag), 0);
    chk("rst_br_target", 32'(br_target), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    rst = 1'b0;
    @(negedge clk);

    alu_op(OP_ADD, 32'h7FFFFFFF, 0, 16'h0001, 1, 6'd5, 32'h80000000);
    alu_op(OP_SRA, 32'h80000000, 4, 16'h0, 0, 6'd6, 32'hF8000000);
    alu_op(OP_SUB, 5, 7, 16'h0, 0, 6'd2, 32'hFFFFFFFE);
    alu_op(OP_AND, 32'hF0F0, 32'h0FF0, 16'h0, 0, 6'd3, 32'h00F0);
    alu_op(OP_OR, 32'hF0F0, 32'h0FF0, 16'h0, 0, 6'd4, 32'hFFF0);
    alu_op(OP_XOR, 32'hF0F0, 32'h0FF0, 16'h0, 0, 6'd8, 32'hFF00);
    alu_op(OP_SLT, 32'hFFFFFFFF, 1, 16'h0, 0, 6'd9, 1);
    alu_op(OP_SLT, 1, 32'hFFFFFFFF, 16'h0, 0, 6'd10, 0);
    alu_op(OP_SLL, 1, 31, 16'h0, 0, 6'd11, 32'h80000000);
    alu_op(OP_SRL, 32'h80000000, 4, 16'h0, 0, 6'd12, 32'h08000000);
    alu_op(OP_LUI, 32'hABCD5678, 0, 16'h1234, 1, 6'd13, 32'h12345678);
    alu_op(OP_ADD, 10, 0, 16'hFFFF, 1, 6'd14, 9);
    issue(OP_NOP, 1, 2, 16'h0, 0, 6'd1, 14'h0, 14'h0, 0,
          1, 0, 6'd0, 0, 0, 0, 0, 14'h0, a0);

    br_op(OP_BLT, 32'hFFFFFFFD, 2, 16'h0100, 14'h3FFF, 14'h0, 0,
          1, 1, 14'h0100, 0, 0);
    br_op(OP_BLT, 5, 2, 16'h0100, 14'h3FFF, 14'h0, 0,
          0, 0, 14'h0000, 0, 0);
    br_op(OP_BEQ, 4, 4, 16'h0020, 14'h0005, 14'h0, 1,
          1, 0, 14'h0020, 0, 0);
    br_op(OP_BNE, 4, 4, 16'h0020, 14'h0005, 14'h0, 1,
          0, 1, 14'h0006, 0, 0);
    br_op(OP_BLE, 2, 2, 16'h0030, 14'h0010, 14'h0, 0,
          1, 1, 14'h0030, 0, 0);
    br_op(OP_JR, 32'h200, 0, 16'h0, 14'h0040, 14'h0200, 0,
          1, 0, 14'h0200, 0, 0);
    br_op(OP_JALR, 32'h123, 0, 16'h0, 14'h0010, 14'h0123, 0,
          1, 0, 14'h0123, 1, 32'h11);
    br_op(OP_JALR, 32'h123, 0, 16'h0, 14'h0010, 14'h0124, 0,
          1, 1, 14'h0123, 1, 32'h11);
    drain();

    mc_op(OP_MUL, 32'hFFFFFFF9, 6, 6'd7, 3, 1, 32'hFFFFFFD6, a0);
    chk("mul_busy", 32'(busy), 1);
    chk("mul_ready_lo1", 32'(in_ready), 0);
    @(negedge clk);
    chk("mul_ready_lo2", 32'(in_ready), 0);
    @(negedge clk);
    chk("mul_ready_lo3", 32'(in_ready), 0);
    issue(OP_ADD, 1, 2, 16'h0, 0, 6'd15, 14'h0, 14'h0, 0,
          1, 1, 6'd15, 3, 0, 0, 0, 14'h0, a1);
    chk("add_holdoff", a1, a0 + 4);
    drain();

    mc_op(OP_DIV, 32'hFFFFFFF9, 2, 6'd16, 34, 1, 32'hFFFFFFFD, a0);
    mc_op(OP_REM, 32'hFFFFFFF9, 2, 6'd17, 34, 1, 32'hFFFFFFFF, a0);
    mc_op(OP_DIV, 5, 0, 6'd18, 34, 1, 32'hFFFFFFFF, a0);
    mc_op(OP_DIV, 32'hFFFFFFF9, 0, 6'd19, 34, 1, 32'hFFFFFFFF, a0);
    mc_op(OP_REM, 32'hFFFFFFF9, 0, 6'd20, 34, 1, 32'hFFFFFFF9, a0);
    mc_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 6'd21, 34, 1,
          32'h80000000, a0);
    mc_op(OP_REM, 32'h80000000, 32'hFFFFFFFF, 6'd22, 34, 1, 0, a0);
    mc_op(OP_DIV, 100, 32'hFFFFFFF9, 6'd23, 34, 1, 32'hFFFFFFF2, a0);
    mc_op(OP_REM, 100, 32'hFFFFFFF9, 6'd24, 34, 1, 2, a0);
    drain();

    flush = 1'b1; in_valid = 1'b1; in_op = OP_ADD;
    in_rs_val = 1; in_use_imm = 1'b0; in_rt_val = 1; in_dd = 6'd25;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_idle_ready", 32'(in_ready), 1);
    repeat (3) @(negedge clk);

    mc_op(OP_DIV, 100, 7, 6'd26, 34, 0, 0, a0);
    repeat (8) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_ready", 32'(in_ready), 1);
    chk("flush_wb_valid", 32'(wb_valid), 0);
    chk("flush_busy", 32'(busy), 0);
    repeat (40) @(negedge clk);
    alu_op(OP_ADD, 1, 2, 16'h0, 0, 6'd27, 3);
    drain();

    mc_op(OP_MUL, 3, 3, 6'd28, 3, 0, 0, a0);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_wb_valid", 32'(wb_valid), 0);
    chk("rstmid_wb_val", wb_val, 0);
    chk("rstmid_wb_tag", 32'(wb_tag), 0);
    chk("rstmid_br_target", 32'(br_target), 0);
    chk("rstmid_br_pc", 32'(br_pc), 0);
    chk("rstmid_busy", 32'(busy), 0);
    chk("rstmid_ready", 32'(in_ready), 1);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
